// File: rtl/writeback_pkg.sv
// Shared encodings for the writeback commit stage.
// Optional feature macro used by the top level: WB_RETIRE_CNT_EN.
package writeback_pkg;

  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_REG  = 2'd1,
    KIND_MEM  = 2'd2
  } dst_kind_e;

  typedef enum logic [1:0] {
    WIDTH_BYTE  = 2'd0,
    WIDTH_WORD  = 2'd1,
    WIDTH_DWORD = 2'd2
  } width_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR0    = 3'd1,
    ST_WR1    = 3'd2,
    ST_COMMIT = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  // Bit 1 of EFLAGS is architecturally reserved and always reads one.
  localparam logic [31:0] RESET_EFLAGS_DEFAULT = 32'h0000_0002;

  // Everything captured from execute at the accept edge.
  typedef struct packed {
    logic [31:0] opnd0;
    logic [31:0] opnd1;
    logic [31:0] eflags;
    logic [31:0] next_eip;
    logic [1:0]  dst0_kind;
    logic [1:0]  dst1_kind;
    logic [2:0]  dst0_reg;
    logic [2:0]  dst1_reg;
    logic [31:0] dst0_addr;
    logic [31:0] dst1_addr;
    logic [1:0]  width;
  } txn_t;

  // Reserved kind 3 behaves as NONE, so only REG and MEM count as work.
  function automatic logic kind_active(input logic [1:0] kind);
    return (kind == KIND_REG) || (kind == KIND_MEM);
  endfunction

  // Reserved width 3 behaves as a dword access.
  function automatic logic [1:0] norm_width(input logic [1:0] width);
    return (width == 2'd3) ? 2'd2 : width;
  endfunction

  // A memory access may not straddle a dword boundary.
  function automatic logic misaligned(input logic [1:0] kind,
                                      input logic [1:0] width,
                                      input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    if (kind == KIND_MEM) begin
      case (width)
        WIDTH_WORD:  bad = (offset == 2'd3);
        WIDTH_DWORD: bad = (offset != 2'd0);
        default:     bad = 1'b0;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/writeback_lane_align.sv
// Places an operand into its byte lanes and produces the matching byte mask.
module writeback_lane_align
  import writeback_pkg::*;
(
  input  logic [1:0]  width,
  input  logic [1:0]  offset,
  input  logic [31:0] data_in,
  output logic [3:0]  mask,
  output logic [31:0] data_out
);

  logic [3:0]  base_mask;
  logic [31:0] trimmed;

  // Trim the operand to its access size, then slide it up to the target lane.
  always_comb begin
    base_mask = 4'b1111;
    trimmed   = data_in;
    case (width)
      WIDTH_BYTE: begin
        base_mask = 4'b0001;
        trimmed   = {24'b0, data_in[7:0]};
      end
      WIDTH_WORD: begin
        base_mask = 4'b0011;
        trimmed   = {16'b0, data_in[15:0]};
      end
      default: begin
        base_mask = 4'b1111;
        trimmed   = data_in;
      end
    endcase
    mask     = base_mask << offset;
    data_out = trimmed << {offset, 3'b000};
  end

endmodule

// File: rtl/writeback.sv
// Writeback/commit stage: writes up to two destinations in order, then
// updates the architectural EFLAGS and EIP.
// Optional retired-instruction counter enabled by macro WB_RETIRE_CNT_EN.
module writeback
  import writeback_pkg::*;
#(
  parameter logic [31:0] RESET_EIP    = 32'h0000_0000,
  parameter logic [31:0] RESET_EFLAGS = RESET_EFLAGS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_opnd0_w,
  input  logic [31:0] in_opnd1_w,
  input  logic [31:0] in_eflags,
  input  logic [31:0] in_next_eip,
  input  logic [1:0]  in_dst0_kind,
  input  logic [1:0]  in_dst1_kind,
  input  logic [2:0]  in_dst0_reg,
  input  logic [2:0]  in_dst1_reg,
  input  logic [31:0] in_dst0_addr,
  input  logic [31:0] in_dst1_addr,
  input  logic [1:0]  in_width,
  output logic        rf_we,
  output logic [2:0]  rf_idx,
  output logic [31:0] rf_wdata,
  output logic [3:0]  rf_wmask,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic        mem_err,
  output logic [31:0] eflags,
  output logic [31:0] eip,
  output logic        retire,
  output logic        fault
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0] retired_cnt
`endif
);

  state_e      state_q, state_d;
  txn_t        txn_q, txn_d;
  logic [31:0] eflags_q, eflags_d;
  logic [31:0] eip_q, eip_d;

  logic        in_wr_state;
  logic        sel_dst1;
  logic [1:0]  cur_kind;
  logic [2:0]  cur_reg;
  logic [31:0] cur_addr;
  logic [31:0] cur_data;
  logic        cur_is_reg;
  logic        cur_is_mem;
  logic        hi_byte;
  state_e      after_dst0;

  logic [1:0]  in_width_n;
  logic        dst0_bad;
  logic        dst1_bad;

  logic [3:0]  gpr_mask;
  logic [31:0] gpr_data;
  logic [3:0]  mem_mask_al;
  logic [31:0] mem_data_al;

  // Select which latched destination the current write state is working on.
  always_comb begin
    in_wr_state = (state_q == ST_WR0) || (state_q == ST_WR1);
    sel_dst1    = (state_q == ST_WR1);
    cur_kind    = sel_dst1 ? txn_q.dst1_kind : txn_q.dst0_kind;
    cur_reg     = sel_dst1 ? txn_q.dst1_reg  : txn_q.dst0_reg;
    cur_addr    = sel_dst1 ? txn_q.dst1_addr : txn_q.dst0_addr;
    cur_data    = sel_dst1 ? txn_q.opnd1     : txn_q.opnd0;
    cur_is_reg  = in_wr_state && (cur_kind == KIND_REG);
    cur_is_mem  = in_wr_state && (cur_kind == KIND_MEM);
    hi_byte     = (txn_q.width == WIDTH_BYTE) && cur_reg[2];
    after_dst0  = kind_active(txn_q.dst1_kind) ? ST_WR1 : ST_COMMIT;
  end

  writeback_lane_align u_gpr_align (
    .width    (txn_q.width),
    .offset   ({1'b0, hi_byte}),
    .data_in  (cur_data),
    .mask     (gpr_mask),
    .data_out (gpr_data)
  );

  writeback_lane_align u_mem_align (
    .width    (txn_q.width),
    .offset   (cur_addr[1:0]),
    .data_in  (cur_data),
    .mask     (mem_mask_al),
    .data_out (mem_data_al)
  );

  // Drive the write ports only while a write is in progress; zero otherwise.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    retire    = (state_q == ST_COMMIT);
    fault     = (state_q == ST_FAULT);
    eflags    = eflags_q;
    eip       = eip_q;
    rf_we     = cur_is_reg;
    rf_idx    = 3'd0;
    rf_wdata  = 32'd0;
    rf_wmask  = 4'd0;
    mem_req   = cur_is_mem;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_wmask = 4'd0;
    if (cur_is_reg) begin
      rf_idx   = hi_byte ? {1'b0, cur_reg[1:0]} : cur_reg;
      rf_wdata = gpr_data;
      rf_wmask = gpr_mask;
    end
    if (cur_is_mem) begin
      mem_addr  = {cur_addr[31:2], 2'b00};
      mem_wdata = mem_data_al;
      mem_wmask = mem_mask_al;
    end
  end

  // Sequencing: accept, write dst0, write dst1, commit; faults are absorbing.
  always_comb begin
    state_d    = state_q;
    txn_d      = txn_q;
    eflags_d   = eflags_q;
    eip_d      = eip_q;
    in_width_n = norm_width(in_width);
    dst0_bad   = misaligned(in_dst0_kind, in_width_n, in_dst0_addr[1:0]);
    dst1_bad   = misaligned(in_dst1_kind, in_width_n, in_dst1_addr[1:0]);
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          txn_d.opnd0     = in_opnd0_w;
          txn_d.opnd1     = in_opnd1_w;
          txn_d.eflags    = in_eflags;
          txn_d.next_eip  = in_next_eip;
          txn_d.dst0_kind = in_dst0_kind;
          txn_d.dst1_kind = in_dst1_kind;
          txn_d.dst0_reg  = in_dst0_reg;
          txn_d.dst1_reg  = in_dst1_reg;
          txn_d.dst0_addr = in_dst0_addr;
          txn_d.dst1_addr = in_dst1_addr;
          txn_d.width     = in_width_n;
          if (dst0_bad || dst1_bad) begin
            state_d = ST_FAULT;
          end else if (kind_active(in_dst0_kind)) begin
            state_d = ST_WR0;
          end else if (kind_active(in_dst1_kind)) begin
            state_d = ST_WR1;
          end else begin
            state_d = ST_COMMIT;
          end
        end
      end
      ST_WR0: begin
        if (cur_is_reg) begin
          state_d = after_dst0;
        end else if (mem_ack) begin
          state_d = mem_err ? ST_FAULT : after_dst0;
        end
      end
      ST_WR1: begin
        if (cur_is_reg) begin
          state_d = ST_COMMIT;
        end else if (mem_ack) begin
          state_d = mem_err ? ST_FAULT : ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        eflags_d = txn_q.eflags;
        eip_d    = txn_q.next_eip;
        state_d  = ST_IDLE;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched instruction and architectural registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      txn_q    <= '0;
      eflags_q <= RESET_EFLAGS;
      eip_q    <= RESET_EIP;
    end else begin
      state_q  <= state_d;
      txn_q    <= txn_d;
      eflags_q <= eflags_d;
      eip_q    <= eip_d;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retired_cnt_q, retired_cnt_d;

  // Count commits; wraps naturally and cannot move once faulted.
  always_comb begin
    retired_cnt_d = retired_cnt_q;
    if (state_q == ST_COMMIT) begin
      retired_cnt_d = retired_cnt_q + 32'd1;
    end
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt_q <= 32'd0;
    end else begin
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign retired_cnt = retired_cnt_q;
`endif

endmodule
